// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and hold-limit release
module rr_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] last_id_q, last_id_d;
    logic [7:0]     hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] sel;
    logic [IDW-1:0] srch_idx;
    logic           sel_found;
    logic           rel_done, rel_drop, rel_max;

    // Search starts just past the last owner and wraps at N-1.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        srch_idx  = '0;
        for (int i = 0; i < N; i++) begin
            srch_idx = IDW'((int'(last_id_q) + 1 + i) % N);
            if (!sel_found && req[srch_idx]) begin
                sel       = srch_idx;
                sel_found = 1'b1;
            end
        end
    end

    assign rel_done = done;
    assign rel_drop = !req[gnt_id_q];
    assign rel_max  = (hold_cnt_q == 8'(MAX_HOLD));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d    = BUSY;
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << sel;
                    gnt_id_d   = sel;
                    last_id_d  = sel;
                    hold_cnt_d = 8'd1;
                end
            end
            BUSY: begin
                if (rel_done || rel_drop || rel_max) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = 8'd0;
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_d  = rel_max && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            last_id_q  <= IDW'(N - 1);
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = (state_q == BUSY);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed vector bench for rr_arbiter
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic       exp_to;
    } vec_t;

    vec_t vec [0:21];

    rr_arbiter #(.N(8), .IDW(3), .MAX_HOLD(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [2:0] id, input logic to);
        logic [7:0] eg;
        eg = v ? (8'b1 << id) : 8'b0;
        check({name, ".gnt"}, 32'(gnt), 32'(eg));
        check({name, ".valid"}, 32'(gnt_valid), 32'(v));
        check({name, ".id"}, 32'(gnt_id), 32'(id));
        check({name, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vec[0]  = '{8'hCC, 1'b0, 1'b1, 3'd2, 1'b0};
        vec[1]  = '{8'hCC, 1'b1, 1'b0, 3'd2, 1'b0};
        vec[2]  = '{8'hCC, 1'b0, 1'b1, 3'd3, 1'b0};
        vec[3]  = '{8'hCC, 1'b1, 1'b0, 3'd3, 1'b0};
        vec[4]  = '{8'hCC, 1'b0, 1'b1, 3'd6, 1'b0};
        vec[5]  = '{8'hCC, 1'b1, 1'b0, 3'd6, 1'b0};
        vec[6]  = '{8'hCC, 1'b0, 1'b1, 3'd7, 1'b0};
        vec[7]  = '{8'hCC, 1'b1, 1'b0, 3'd7, 1'b0};
        vec[8]  = '{8'hCC, 1'b0, 1'b1, 3'd2, 1'b0};
        vec[9]  = '{8'hCC, 1'b1, 1'b0, 3'd2, 1'b0};
        vec[10] = '{8'h40, 1'b0, 1'b1, 3'd6, 1'b0};
        vec[11] = '{8'h40, 1'b1, 1'b0, 3'd6, 1'b0};
        vec[12] = '{8'h41, 1'b0, 1'b1, 3'd0, 1'b0};
        vec[13] = '{8'h41, 1'b1, 1'b0, 3'd0, 1'b0};
        vec[14] = '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0};
        vec[15] = '{8'h00, 1'b0, 1'b0, 3'd3, 1'b0};
        vec[16] = '{8'h00, 1'b1, 1'b0, 3'd3, 1'b0};
        vec[17] = '{8'h09, 1'b0, 1'b1, 3'd0, 1'b0};
        vec[18] = '{8'h0F, 1'b0, 1'b1, 3'd0, 1'b0};
        vec[19] = '{8'h0F, 1'b1, 1'b0, 3'd0, 1'b0};
        vec[20] = '{8'h0F, 1'b0, 1'b1, 3'd1, 1'b0};
        vec[21] = '{8'h0E, 1'b0, 1'b1, 3'd1, 1'b0};

        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #2;
        check_out("reset", 1'b0, 3'd0, 1'b0);
        do_reset();
        check_out("reset_rel", 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 22; i++) begin
            req  = vec[i].req;
            done = vec[i].done;
            step();
            check_out($sformatf("vec%0d", i), vec[i].exp_valid, vec[i].exp_id, vec[i].exp_to);
        end

        // Full request vector, done on every granted cycle
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            done = 1'b0;
            step();
            check_out($sformatf("all_g%0d", k), 1'b1, 3'(k % 8), 1'b0);
            check($sformatf("all_onehot%0d", k), 32'($countones(gnt)), 32'd1);
            done = 1'b1;
            step();
            check_out($sformatf("all_i%0d", k), 1'b0, 3'(k % 8), 1'b0);
        end

        // Single requester held through the hold limit
        do_reset();
        req  = 8'h01;
        done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            check_out($sformatf("hold%0d", k), 1'b1, 3'd0, 1'b0);
        end
        step();
        check_out("hold_timeout", 1'b0, 3'd0, 1'b1);
        step();
        check_out("hold_regrant", 1'b1, 3'd0, 1'b0);
        for (int k = 0; k < 14; k++) step();
        check_out("hold2_last", 1'b1, 3'd0, 1'b0);
        done = 1'b1;
        step();
        check_out("done_at_limit", 1'b0, 3'd0, 1'b0);
        done = 1'b0;

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 8'h10;
        for (int k = 0; k < 5; k++) step();
        check_out("mid_pre", 1'b1, 3'd4, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst.gnt", 32'(gnt), 32'd0);
        check("mid_rst.valid", 32'(gnt_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_out("mid_idle", 1'b0, 3'd0, 1'b0);
        step();
        check_out("mid_regrant", 1'b1, 3'd4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one downstream resource among up to eight requesters, using the priority-encoder search as its selection core. It sits between the request lines of client blocks and the shared datapath. It issues a registered one-hot grant plus encoded index, holds the grant until the owner releases it, and force-releases owners that exceed a hold limit. Fairness comes from rotating the search start point to just past the last granted requester.

## Interface
- N, 8: number of requesters. Legal values are 2..8.
- IDW, 3: width of the encoded grant index; equals ceil(log2(N)).
- MAX_HOLD, 15: maximum number of cycles a grant may be held before forced release. Legal values are 1..255.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- done  input  1  the current owner releases the grant; ignored when gnt_valid=0.
- gnt  output  N  one-hot grant, registered; all zero when idle.
- gnt_id  output  IDW  binary index of the granted requester; holds its last value when idle.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released.

## Operation
- States:
  - IDLE: no grant active.
  - BUSY: grant held.
- Internal registers:
  - last_id (IDW bits): most recently granted index; reset value N-1.
  - hold_cnt (8 bits): cycles the current grant has been held.
- Selection (combinational, evaluated in IDLE):
  - Search req starting at index last_id+1 mod N, upward, wrapping at N-1 to 0.
  - The first set bit wins.
  - Equivalent: rotate req right by last_id+1, priority-encode for the lowest set bit, then add the offset back mod N.
- IDLE -> BUSY when req != 0 at a rising edge.
  - gnt = one-hot(sel), gnt_id = sel, gnt_valid = 1.
  - last_id = sel, hold_cnt = 1.
- BUSY -> IDLE at a rising edge when any of these holds:
  - (a) done = 1.
  - (b) req[gnt_id] = 0, meaning the owner dropped its request.
  - (c) hold_cnt = MAX_HOLD. The timeout pulse is issued only in case (c) when neither (a) nor (b) holds.
- On BUSY -> IDLE: gnt = 0, gnt_valid = 0, hold_cnt = 0. gnt_id and last_id are retained.
- BUSY with no exit condition: hold_cnt increments. It saturates and never wraps, because exit occurs at MAX_HOLD.
- req changes on non-owner bits during BUSY have no effect on the active grant.
- There is never more than one gnt bit high. gnt is a pure function of registered state, with no combinational path from req.
- Bits of req at or above index N do not exist; N < 8 simply narrows the vectors.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - State = IDLE.
  - gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0.
  - last_id = N-1, so the first search starts at index 0.
  - hold_cnt = 0.
- Grant latency: req sampled at edge k yields gnt valid after edge k (one cycle from request to grant).
- Release latency: done sampled high at edge k drops gnt after edge k.
- Minimum of one idle cycle (gnt_valid = 0) between consecutive grants, even with requests pending.
- Maximum continuous ownership is MAX_HOLD cycles. With MAX_HOLD=15, gnt_valid stays high for exactly 15 cycles before a forced release.
- Worst-case wait for a continuously asserted request: (N-1) × (MAX_HOLD+1) cycles.
- timeout is high for exactly the one cycle following the forced-release edge.
- Simultaneous events:
  - done together with timeout: treated as a normal release, no pulse.
  - done while idle: ignored.
  - Reset asserted mid-grant: gnt drops immediately (asynchronously), and last_id returns to N-1.

## Test plan
- Reset then req=8'b11001100 held, done pulsed one cycle after each grant:
  - Grants issue in order gnt_id 2, 3, 6, 7, 2.
  - One idle cycle between each grant.
- Single requester req=8'b00000001 held, done never asserted, MAX_HOLD=15:
  - gnt=8'b00000001 for 15 cycles, then timeout pulses once and gnt=0 for one cycle.
  - The regrant goes to id 0 again, because it is the only requester.
- req=8'b11111111 held, done asserted every cycle the grant is valid:
  - gnt_id sequence 0, 1, ..., 7, 0. Each index appears exactly once per 8 grants.
  - gnt is one-hot every cycle.
- Wrap-around: after a grant to id 6 is released, apply req=8'b01000001:
  - The next grant goes to id 0, not id 6.
- Owner drop: grant to id 3, then req[3] deasserted without done:
  - gnt clears at the next edge.
  - timeout stays 0.
- Reset mid-grant at hold_cnt=5 with req=8'b00010000:
  - gnt=0 and gnt_valid=0 immediately on reset.
  - After reset release, grant to id 4 one cycle later.
